tfifo_n: RTL
============

Name: tfifo_n

Overview:
Parametrised-depth, parametrised-width FIFO with the codebase's ACT/NEXT handshake on both sides. It is the successor to the fixed 2-entry skid stage. Adds configurable depth, a registered occupancy count, an almost-full flag and a synchronous flush. It sits between cores and buses wherever more than two words of elasticity are needed.

Parameters:
Width, 32, data word width in bits (>=1)
Depth, 4, storage array entries; power of two, >=2
AfThresh, 3, AFULL asserts when LEVEL >= AfThresh; legal range 1..Depth

Ports:
CLK  in  1  single clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
FLUSH  in  1  synchronous discard of all contents, same effect as RESET
ACTL  in  1  source has a valid word on DI
NEXTL  out  1  FIFO can accept a word; combinational from registered LEVEL
DI  in  Width  input data
ACTH  out  1  DO holds a valid word (registered)
NEXTH  in  1  sink takes DO this cycle
DO  out  Width  output data (registered)
LEVEL  out  $clog2(Depth)+1  array occupancy 0..Depth; excludes the output register
AFULL  out  1  registered, LEVEL >= AfThresh

Behaviour:
- Reset/flush: on a clock edge with RESET or FLUSH high, the following take effect next cycle:
  - LEVEL=0, write/read pointers=0, ACTH=0, DO=0, AFULL=0, so NEXTL=1.
  - Any ACTL or NEXTH in that cycle is ignored; a word offered then is not stored and must be re-offered.
- Write: accepted at an edge when ACTL & NEXTL & ~RESET & ~FLUSH.
  - DI is stored at the write pointer; the write pointer increments modulo Depth (natural wrap, Depth is a power of two).
- NEXTL = (LEVEL != Depth).
  - A full FIFO does not accept a write in the same cycle as a read; NEXTL rises the cycle after LEVEL drops.
  - The source holds ACTL/DI stable while NEXTL=0. This is a stall, not an error.
- Output advance condition: adv = (~ACTH | NEXTH).
  - On adv with LEVEL != 0: DO <= array[read ptr], read pointer increments, ACTH <= 1.
  - On adv with LEVEL == 0: ACTH <= 0, DO unchanged.
  - While ACTH & ~NEXTH: DO and ACTH hold.
- LEVEL update: +1 on write only, -1 on array read only, unchanged when both occur or neither.
- AFULL is computed from the next LEVEL value and registered, so it is coincident with LEVEL.
- Latency: a word written at edge k into an empty FIFO with ACTH=0 appears with ACTH=1 after edge k+1 (2 cycles ACTL-to-ACTH). There is no write-to-output bypass.
- Throughput: 1 word/cycle in steady state with NEXTH held high.
- Ordering is strict FIFO; no word is duplicated or lost except by RESET/FLUSH.
- Total buffering is Depth+1 words (array plus output register).
- No overflow or underflow is possible through the ports.

Decomposition:
- Package tfifo_pkg:
  - function lvl_w(depth) returning $clog2(depth)+1.
  - Elaboration-time checks (power-of-two Depth, AfThresh range) as constants/asserts.
- Sub-module tfifo_ram: simple dual-port array with a Width x Depth write port and an asynchronous read at the read pointer. This lets the array map to distributed RAM.
- Control (pointers, LEVEL, ACTH/DO register) stays in tfifo_n.

Test Plan:
1. Single word: Depth=4, empty, ACTL=1 DI=0xA5A5_0001 for 1 cycle, NEXTH=1 -> ACTH=1 DO=0xA5A5_0001 exactly 2 cycles after ACTL; LEVEL 0->1->0.
2. Fill/stall: NEXTH=0, push 0x10..0x15 back-to-back -> 0x10 in DO, 0x11..0x14 stored, LEVEL=4, NEXTL=0, AFULL=1 from LEVEL=3. 0x15 held by the source; after NEXTH=1, it is accepted the cycle after NEXTL rises. Output order is 0x10..0x15.
3. Wrap: Depth=4, stream 20 incrementing words with NEXTH toggling 1,0,1,0 -> all 20 words out in order, none missing or duplicated; LEVEL never exceeds 4.
4. Simultaneous read/write: LEVEL=2, ACTL=1 and NEXTH=1 for 5 cycles -> LEVEL stays 2; 5 words in and 5 out in order.
5. Flush mid-stream: LEVEL=3, ACTH=1, assert FLUSH with ACTL=1 DI=0x77 -> next cycle LEVEL=0, ACTH=0, DO=0, NEXTL=1; 0x77 is not stored.
6. Reset mid-operation: RESET=1 for 1 cycle while full and NEXTH=0 -> all outputs at reset values next cycle; the first post-reset word DI=0x3 emerges as the only output.

Source files
------------

// File: rtl/tfifo_pkg.sv
// Shared types and elaboration helpers for the parametrised ACT/NEXT FIFO.
// Everything here is constant-evaluable so it can size ports and guard parameters.
package tfifo_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    // Width of the occupancy count: must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_ok(input int af_thresh, input int depth);
        return (af_thresh >= 1) && (af_thresh <= depth);
    endfunction

endpackage

// File: rtl/tfifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// The combinational read lets small depths map onto distributed RAM.
module tfifo_ram #(
    parameter int Width = 32,
    parameter int Depth = 4,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tfifo_n.sv
// Parametrised-depth FIFO with ACT/NEXT handshakes on both sides, a registered
// output stage, registered occupancy count, almost-full flag and synchronous flush.
module tfifo_n
    import tfifo_pkg::*;
#(
    parameter int Width    = 32,
    parameter int Depth    = 4,
    parameter int AfThresh = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FLUSH,
    input  logic                    ACTL,
    output logic                    NEXTL,
    input  logic [Width-1:0]        DI,
    output logic                    ACTH,
    input  logic                    NEXTH,
    output logic [Width-1:0]        DO,
    output logic [lvl_w(Depth)-1:0] LEVEL,
    output logic                    AFULL
);

    localparam int AW = $clog2(Depth);
    localparam int LW = lvl_w(Depth);
    localparam logic [LW-1:0] FULL_LVL = LW'(Depth);
    localparam logic [LW-1:0] AF_LVL   = LW'(AfThresh);

    if (!is_pow2(Depth)) begin : g_bad_depth
        $error("tfifo_n: Depth must be a power of two and at least 2");
    end
    if (!af_ok(AfThresh, Depth)) begin : g_bad_afthresh
        $error("tfifo_n: AfThresh must lie in 1..Depth");
    end

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [LW-1:0]    level_next;
    logic             afull_reg;
    logic             afull_next;
    logic             acth_reg;
    logic [Width-1:0] do_reg;
    logic [Width-1:0] ram_rdata;

    logic    clr;
    logic    adv;
    logic    nextl;
    logic    wr_en;
    logic    rd_en;
    lvl_op_e lvl_op;

    tfifo_ram #(
        .Width(Width),
        .Depth(Depth),
        .AddrW(AW)
    ) u_ram (
        .clk  (CLK),
        .we   (wr_en),
        .waddr(wr_ptr_reg),
        .wdata(DI),
        .raddr(rd_ptr_reg),
        .rdata(ram_rdata)
    );

    // A full array refuses writes even when a read frees a slot this cycle,
    // keeping NEXTL a pure function of registered state.
    always_comb begin
        clr    = RESET | FLUSH;
        adv    = ~acth_reg | NEXTH;
        nextl  = (level_reg != FULL_LVL);
        wr_en  = ACTL & nextl & ~clr;
        rd_en  = adv & (level_reg != '0) & ~clr;
        lvl_op = LVL_HOLD;
        if (wr_en && !rd_en) begin
            lvl_op = LVL_INC;
        end else if (rd_en && !wr_en) begin
            lvl_op = LVL_DEC;
        end
    end

    always_comb begin
        level_next = level_reg;
        unique case (lvl_op)
            LVL_INC:  level_next = level_reg + 1'b1;
            LVL_DEC:  level_next = level_reg - 1'b1;
            LVL_HOLD: level_next = level_reg;
            default:  level_next = level_reg;
        endcase
        if (clr) begin
            level_next = '0;
        end
        afull_next = (level_next >= AF_LVL);
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            afull_reg  <= 1'b0;
            acth_reg   <= 1'b0;
            do_reg     <= '0;
        end else begin
            level_reg <= level_next;
            afull_reg <= afull_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                do_reg     <= ram_rdata;
                acth_reg   <= 1'b1;
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end else if (adv) begin
                acth_reg <= 1'b0;
            end
        end
    end

    // Occupancy must always agree with the pointer distance and stay bounded.
    always_ff @(posedge CLK) begin
        if (!clr) begin
            assert (level_reg <= FULL_LVL);
            assert (AW'(level_reg) == AW'(wr_ptr_reg - rd_ptr_reg));
        end
    end

    assign NEXTL = nextl;
    assign ACTH  = acth_reg;
    assign DO    = do_reg;
    assign LEVEL = level_reg;
    assign AFULL = afull_reg;

endmodule
